pcs_block_lock_ctrl: RTL and testbench
======================================

// Module: pcs_block_lock_ctrl
// PURPOSE
//  64b/66b block-sync controller in front of the 25G PCS descrambler. Watches the 2-bit sync
//  header per received block, runs the lock FSM, and issues one-cycle slip requests to the gearbox.
//  Gates descrambler in_enable/in_pop, and flags output valid once the 58-bit history is primed.
// PARAMETERS
//  UNITWIDTH    64  payload bits per block; descrambler data width
//  SH_CNT_MAX   64  headers per test window
//  INVALID_MAX  16  invalid headers in one window that drop lock
//  SLIP_WAIT    4   clk cycles after a slip during which in_pop is ignored (gearbox settle)
//  WARMUP_POPS  1   locked pops before descrambler output is valid; equals ceil(58/UNITWIDTH)
// PORTS
//  clk          in   1  clock
//  reset_n      in   1  asynchronous active-low reset
//  in_pop       in   1  block present this cycle (sh valid)
//  sh           in   2  sync header of current block
//  slip         out  1  one-cycle pulse: gearbox shifts alignment by 1 bit
//  block_lock   out  1  registered lock status
//  descr_enable out  1  to descrambler in_enable; equals block_lock
//  descr_pop    out  1  to descrambler in_pop; comb in_pop & block_lock & state==TEST
//  out_valid    out  1  comb descr_pop & warm_done; descrambled word is valid
//  slip_count   out  8  saturating count of slips since reset
// BEHAVIOUR
//  Reset (async, reset_n=0): state=INIT; block_lock=0; slip=0; slip_count=0; sh_cnt=0;
//   inv_cnt=0; warm_cnt=0; descr_pop=0; out_valid=0.
//  States: INIT -> TEST next cycle, with counters cleared.
//  TEST, per in_pop: good = (sh==2'b01 || sh==2'b10); sh_cnt+1; inv_cnt+1 if !good.
//   unlocked & !good         -> SLIP (any bad header while hunting)
//   locked & inv_cnt+1==INVALID_MAX -> SLIP; block_lock<=0 in the same edge
//   sh_cnt+1==SH_CNT_MAX, no slip above:
//     unlocked -> block_lock<=1; locked -> keep lock. Clear both counters.
//  SLIP (1 cycle): slip=1; slip_count+1, saturating at 255; block_lock=0; warm_cnt=0 -> WAIT.
//  WAIT: SLIP_WAIT cycles with in_pop ignored (no counting, descr_pop=0) -> TEST, counters cleared.
//  Width rules:
//   sh_cnt is $clog2(SH_CNT_MAX+1) bits; inv_cnt is $clog2(INVALID_MAX+1) bits; neither wraps.
//   Both clear on window end or on leaving TEST.
//  Warm-up: warm_cnt counts descr_pop up to WARMUP_POPS and saturates.
//   warm_done = (warm_cnt==WARMUP_POPS). Cleared when block_lock falls.
//  Simultaneous events:
//   Window end and INVALID_MAX on the same pop: SLIP wins.
//   Unlocked window end with a bad last header: SLIP, lock not asserted.
//  Latency: slip rises 1 cycle after the offending pop is sampled; block_lock rises 1 cycle after
//   the 64th good pop. descr_pop/out_valid are combinational from in_pop.
//  Reset mid-operation: all state clears immediately; a pending slip pulse is cancelled.
//  in_pop=0 cycles are idle; no counter moves.
// STRUCTURE
//  Package pcs25g_pkg: state enum {INIT,TEST,SLIP,WAIT}; SH_DATA=2'b01; SH_CTRL=2'b10;
//   DESCR_TAPS=58. Shared with the descrambler and gearbox.
//  Single flat module; no sub-module warranted.
//  Counters and FSM in one always block, async reset. Output decode in continuous assigns.
// TESTING
//  1 Reset, then 64 pops sh=01 -> block_lock=1 on cycle after pop 64; slip never pulses;
//    descr_pop starts next pop; out_valid on the 2nd locked pop (UNITWIDTH=64).
//  2 Unlocked, pop 10 has sh=00 -> slip pulse 1 cycle; next 4 cycles' pops ignored;
//    slip_count=1; hunting restarts with counters cleared.
//  3 Locked, 15 bad of 64 in window -> lock held, counters clear.
//    Next window, 16th bad header -> block_lock=0 and slip=1 the following cycle.
//  4 Locked, window end coincides with 16th bad -> slip, lock lost.
//    Unlocked window where pop 64 is sh=11 -> slip, no lock.
//  5 300 forced slips -> slip_count saturates at 255.
//    reset_n low mid-WAIT -> all outputs 0 asynchronously; restart from INIT.
//  6 Random sh with sparse in_pop gaps vs reference FSM model -> bit-exact
//    block_lock/slip/out_valid match.

Source files
------------

// File: rtl/pcs25g_pkg.sv
// Shared definitions for the 25G PCS receive path: block-lock FSM states,
// sync header encodings and descrambler history length.
package pcs25g_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        TEST = 2'd1,
        SLIP = 2'd2,
        WAIT = 2'd3
    } lock_state_t;

    localparam logic [1:0]  SH_DATA    = 2'b01;
    localparam logic [1:0]  SH_CTRL    = 2'b10;
    localparam int unsigned DESCR_TAPS = 58;

    // A sync header is valid only when its two bits differ.
    function automatic logic sh_is_good(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage

// File: rtl/pcs_block_lock_ctrl.sv
// 64b/66b block-sync controller: hunts for sync-header alignment, requests
// one-bit gearbox slips, holds lock across test windows and gates the
// descrambler until its history is primed.
module pcs_block_lock_ctrl
    import pcs25g_pkg::*;
#(
    parameter int unsigned UNITWIDTH   = 64,
    parameter int unsigned SH_CNT_MAX  = 64,
    parameter int unsigned INVALID_MAX = 16,
    parameter int unsigned SLIP_WAIT   = 4,
    parameter int unsigned WARMUP_POPS = (DESCR_TAPS + UNITWIDTH - 1) / UNITWIDTH
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_pop,
    input  logic [1:0] sh,
    output logic       slip,
    output logic       block_lock,
    output logic       descr_enable,
    output logic       descr_pop,
    output logic       out_valid,
    output logic [7:0] slip_count
);

    localparam int unsigned SH_W   = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned INV_W  = $clog2(INVALID_MAX + 1);
    localparam int unsigned WARM_W = $clog2(WARMUP_POPS + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

    lock_state_t       state_q, state_d;
    logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d, sh_nxt;
    logic [INV_W-1:0]  inv_cnt_q, inv_cnt_d, inv_nxt;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]        slip_cnt_q, slip_cnt_d;
    logic              lock_q, lock_d;
    logic              good;

    // Next-state and counter update; a slip decision takes priority over window end.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        warm_cnt_d = warm_cnt_q;
        wait_cnt_d = wait_cnt_q;
        slip_cnt_d = slip_cnt_q;
        lock_d     = lock_q;
        good       = sh_is_good(sh);
        sh_nxt     = sh_cnt_q + 1'b1;
        inv_nxt    = inv_cnt_q + INV_W'(!good);

        unique case (state_q)
            INIT: begin
                state_d   = TEST;
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
            end
            TEST: begin
                if (in_pop) begin
                    if (!lock_q && !good) begin
                        state_d   = SLIP;
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else if (lock_q && inv_nxt == INV_W'(INVALID_MAX)) begin
                        state_d    = SLIP;
                        lock_d     = 1'b0;
                        warm_cnt_d = '0;
                        sh_cnt_d   = '0;
                        inv_cnt_d  = '0;
                    end else begin
                        if (lock_q && warm_cnt_q != WARM_W'(WARMUP_POPS))
                            warm_cnt_d = warm_cnt_q + 1'b1;
                        if (sh_nxt == SH_W'(SH_CNT_MAX)) begin
                            lock_d    = 1'b1;
                            sh_cnt_d  = '0;
                            inv_cnt_d = '0;
                        end else begin
                            sh_cnt_d  = sh_nxt;
                            inv_cnt_d = inv_nxt;
                        end
                    end
                end
            end
            SLIP: begin
                if (slip_cnt_q != 8'hFF)
                    slip_cnt_d = slip_cnt_q + 8'd1;
                lock_d     = 1'b0;
                warm_cnt_d = '0;
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                    state_d   = TEST;
                    sh_cnt_d  = '0;
                    inv_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            warm_cnt_q <= '0;
            wait_cnt_q <= '0;
            slip_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            slip_cnt_q <= slip_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign slip         = (state_q == SLIP);
    assign block_lock   = lock_q;
    assign descr_enable = lock_q;
    assign descr_pop    = in_pop & lock_q & (state_q == TEST);
    assign out_valid    = descr_pop & (warm_cnt_q == WARM_W'(WARMUP_POPS));
    assign slip_count   = slip_cnt_q;

endmodule

// File: tb/tb_pcs_block_lock_ctrl.sv
// Directed and model-based bench for the block-lock controller.
module tb_pcs_block_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_pop = 1'b0;
    logic [1:0] sh = 2'b00;
    logic       slip, block_lock, descr_enable, descr_pop, out_valid;
    logic [7:0] slip_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit seen_slip;

    // Reference model state (0 INIT, 1 TEST, 2 SLIP, 3 WAIT)
    int m_state, m_sh, m_inv, m_warm, m_wait, m_cnt, m_lock;

    pcs_block_lock_ctrl #(
        .UNITWIDTH   (64),
        .SH_CNT_MAX  (64),
        .INVALID_MAX (16),
        .SLIP_WAIT   (4),
        .WARMUP_POPS (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_pop       (in_pop),
        .sh           (sh),
        .slip         (slip),
        .block_lock   (block_lock),
        .descr_enable (descr_enable),
        .descr_pop    (descr_pop),
        .out_valid    (out_valid),
        .slip_count   (slip_count)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle's inputs after the falling edge; the next rising edge samples them.
    task automatic step(input logic p, input logic [1:0] s);
        @(negedge clk);
        in_pop = p;
        sh     = s;
        #1;
        if (slip) seen_slip = 1'b1;
    endtask

    task automatic pops(input int n, input logic [1:0] s);
        for (int i = 0; i < n; i++) step(1'b1, s);
    endtask

    task automatic release_reset();
        in_pop = 1'b0;
        sh     = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_pop  = 1'b0;
        sh      = 2'b00;
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    task automatic model_reset();
        m_state = 0; m_sh = 0; m_inv = 0; m_warm = 0;
        m_wait = 0; m_cnt = 0; m_lock = 0;
    endtask

    // Reference behaviour for one rising edge with the given inputs.
    task automatic model_edge(input logic p, input logic [1:0] s);
        bit g;
        g = (s == 2'b01) || (s == 2'b10);
        case (m_state)
            0: begin m_state = 1; m_sh = 0; m_inv = 0; end
            1: if (p) begin
                m_sh  = m_sh + 1;
                m_inv = m_inv + (g ? 0 : 1);
                if (m_lock == 0 && !g) begin
                    m_state = 2; m_sh = 0; m_inv = 0;
                end else if (m_lock == 1 && m_inv == 16) begin
                    m_state = 2; m_lock = 0; m_warm = 0; m_sh = 0; m_inv = 0;
                end else begin
                    if (m_lock == 1 && m_warm < 1) m_warm = m_warm + 1;
                    if (m_sh == 64) begin m_lock = 1; m_sh = 0; m_inv = 0; end
                end
            end
            2: begin
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                m_lock = 0; m_warm = 0; m_wait = 0; m_state = 3;
            end
            default: begin
                m_wait = m_wait + 1;
                if (m_wait == 4) begin m_state = 1; m_sh = 0; m_inv = 0; end
            end
        endcase
    endtask

    initial begin
        logic       p, prev_p;
        logic [1:0] s, prev_s;
        int         thr;
        bit         exp_dpop;

        // 1: reset values, then lock acquisition and warm-up
        reset_n = 1'b0; in_pop = 1'b1; sh = 2'b01;
        #3;
        check_eq("rst_lock",  32'(block_lock),   32'd0);
        check_eq("rst_slip",  32'(slip),         32'd0);
        check_eq("rst_cnt",   32'(slip_count),   32'd0);
        check_eq("rst_dpop",  32'(descr_pop),    32'd0);
        check_eq("rst_oval",  32'(out_valid),    32'd0);
        check_eq("rst_den",   32'(descr_enable), 32'd0);
        in_pop = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();
        seen_slip = 1'b0;
        pops(64, 2'b01);
        check_eq("t1_lock_at64",  32'(block_lock), 32'd0);
        check_eq("t1_dpop_at64",  32'(descr_pop),  32'd0);
        step(1'b1, 2'b01);
        check_eq("t1_lock_after", 32'(block_lock),   32'd1);
        check_eq("t1_den",        32'(descr_enable), 32'd1);
        check_eq("t1_dpop_65",    32'(descr_pop),    32'd1);
        check_eq("t1_oval_65",    32'(out_valid),    32'd0);
        step(1'b1, 2'b10);
        check_eq("t1_oval_66",    32'(out_valid),    32'd1);
        step(1'b0, 2'b01);
        check_eq("t1_dpop_idle",  32'(descr_pop),    32'd0);
        check_eq("t1_no_slip",    32'(seen_slip),    32'd0);

        // 2: bad header while hunting, WAIT ignores pops, hunt restarts clean
        do_reset();
        pops(9, 2'b01);
        step(1'b1, 2'b00);
        check_eq("t2_slip_pre",  32'(slip), 32'd0);
        step(1'b1, 2'b00);
        check_eq("t2_slip_hi",   32'(slip), 32'd1);
        check_eq("t2_cnt_pulse", 32'(slip_count), 32'd0);
        seen_slip = 1'b0;
        pops(4, 2'b00);
        check_eq("t2_cnt",       32'(slip_count), 32'd1);
        pops(64, 2'b01);
        check_eq("t2_lock_64",   32'(block_lock), 32'd0);
        step(1'b0, 2'b00);
        check_eq("t2_lock",      32'(block_lock), 32'd1);
        check_eq("t2_no_reslip", 32'(seen_slip),  32'd0);

        // 3: 15 bad in a window keeps lock; 16th bad in next window drops it
        do_reset();
        pops(64, 2'b01);
        seen_slip = 1'b0;
        pops(15, 2'b11);
        pops(49, 2'b01);
        step(1'b0, 2'b00);
        check_eq("t3_held",     32'(block_lock), 32'd1);
        check_eq("t3_no_slip",  32'(seen_slip),  32'd0);
        pops(15, 2'b00);
        step(1'b1, 2'b11);
        check_eq("t3_lock_16",  32'(block_lock), 32'd1);
        check_eq("t3_slip_16",  32'(slip),       32'd0);
        step(1'b0, 2'b00);
        check_eq("t3_lost",     32'(block_lock),   32'd0);
        check_eq("t3_slip",     32'(slip),         32'd1);
        check_eq("t3_den",      32'(descr_enable), 32'd0);

        // 4: window end coincident with 16th bad; unlocked window with bad last header
        do_reset();
        pops(64, 2'b01);
        pops(48, 2'b10);
        pops(15, 2'b00);
        step(1'b1, 2'b11);
        check_eq("t4_lock_pre", 32'(block_lock), 32'd1);
        step(1'b0, 2'b00);
        check_eq("t4_slip",     32'(slip),       32'd1);
        check_eq("t4_lost",     32'(block_lock), 32'd0);
        repeat (4) step(1'b0, 2'b00);
        pops(63, 2'b01);
        step(1'b1, 2'b11);
        check_eq("t4_nolock63", 32'(block_lock), 32'd0);
        step(1'b0, 2'b00);
        check_eq("t4_slip2",    32'(slip),       32'd1);
        check_eq("t4_nolock",   32'(block_lock), 32'd0);
        step(1'b0, 2'b00);
        check_eq("t4_cnt",      32'(slip_count), 32'd2);

        // 5: slip counter saturation, then async reset mid-WAIT and mid-SLIP
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 2'b00);
            repeat (5) step(1'b0, 2'b00);
            if (i == 99)  check_eq("t5_cnt100", 32'(slip_count), 32'd100);
            if (i == 254) check_eq("t5_cnt255", 32'(slip_count), 32'd255);
        end
        check_eq("t5_sat", 32'(slip_count), 32'd255);
        step(1'b1, 2'b00);
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);
        #2;
        reset_n = 1'b0; in_pop = 1'b1; sh = 2'b01;
        #1;
        check_eq("t5_rst_cnt",  32'(slip_count), 32'd0);
        check_eq("t5_rst_slip", 32'(slip),       32'd0);
        check_eq("t5_rst_lock", 32'(block_lock), 32'd0);
        check_eq("t5_rst_oval", 32'(out_valid),  32'd0);
        release_reset();
        step(1'b1, 2'b11);
        step(1'b0, 2'b00);
        check_eq("t5_pend_slip", 32'(slip), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t5_cancel", 32'(slip), 32'd0);
        release_reset();
        pops(64, 2'b10);
        step(1'b0, 2'b00);
        check_eq("t5_relock",   32'(block_lock), 32'd1);
        check_eq("t5_cnt_zero", 32'(slip_count), 32'd0);

        // 6: random headers with sparse pops against the reference model
        do_reset();
        model_reset();
        prev_p = 1'b0;
        prev_s = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            model_edge(prev_p, prev_s);
            thr = (i >= 1000 && i < 2000) ? 22 : 1;
            p = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < thr)
                s = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            else
                s = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            step(p, s);
            exp_dpop = p && (m_lock == 1) && (m_state == 1);
            check_eq("t6_lock", 32'(block_lock), 32'(m_lock));
            check_eq("t6_slip", 32'(slip),       32'(m_state == 2));
            check_eq("t6_oval", 32'(out_valid),  32'(exp_dpop && (m_warm == 1)));
            check_eq("t6_cnt",  32'(slip_count), 32'(m_cnt));
            prev_p = p;
            prev_s = s;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
